// File: rtl/bit_serial_logic_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : bit_serial_logic_seq_if
// Brief    : Request/response bundle for the bit-serial logic sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface bit_serial_logic_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result, zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, zero
    );
endinterface
`default_nettype wire

// File: rtl/bit_serial_logic_seq.sv
`default_nettype none
// ============================================================================
// Module   : bit_serial_logic_seq
// Brief    : Applies one 2-input gate to WIDTH-bit operands, one bit per clock,
//            LSB first, with a start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module bit_serial_logic_seq #(
    parameter int WIDTH = 16
) (
    input  wire                   clk,
    input  wire                   rst,
    bit_serial_logic_seq_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_last_idx = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;

    logic             w_bit;
    logic [WIDTH-1:0] w_acc_next;

    always_comb begin
        case (op_q)
            2'b00:   w_bit = a_q[cnt_q] ^ b_q[cnt_q];
            2'b01:   w_bit = a_q[cnt_q] & b_q[cnt_q];
            2'b10:   w_bit = a_q[cnt_q] | b_q[cnt_q];
            default: w_bit = ~(a_q[cnt_q] ^ b_q[cnt_q]);
        endcase
        w_acc_next        = acc_q;
        w_acc_next[cnt_q] = w_bit;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        acc_d    = acc_q;
        result_d = result_q;
        zero_d   = zero_q;

        case (state_q)
            S_IDLE: begin
                // Operands are captured here so later input changes cannot leak in
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    op_d    = bus.op;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = w_acc_next;
                if (cnt_q == c_last_idx) begin
                    cnt_d    = '0;
                    result_d = w_acc_next;
                    zero_d   = (w_acc_next == '0);
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 2'b00;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.busy   = (state_q == S_RUN);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;
    assign bus.zero   = zero_q;
endmodule
`default_nettype wire

// File: tb/tb_bit_serial_logic_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_serial_logic_seq
// Brief    : Self-checking bench: cycle-accurate timing/word-level model plus
//            directed literal vectors and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_serial_logic_seq;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;

    bit_serial_logic_seq_if #(.WIDTH(WIDTH)) bus ();

    bit_serial_logic_seq #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] o,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        case (o)
            2'b00:   return x ^ y;
            2'b01:   return x & y;
            2'b10:   return x | y;
            default: return ~(x ^ y);
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: an operation accepted at edge n_acc is busy after edges
    // n_acc..n_acc+W-1, done after edge n_acc+W, and a new start is
    // only seen from edge n_acc+W+2 on.
    int               n_edge = 0;
    int               n_acc  = 0;
    bit               pend   = 1'b0;
    logic [1:0]       m_op;
    logic [WIDTH-1:0] m_a, m_b;
    logic [WIDTH-1:0] m_res  = '0;
    bit               m_zero = 1'b0;

    always @(posedge clk) begin
        n_edge++;
        if (rst) begin
            pend   = 1'b0;
            m_res  = '0;
            m_zero = 1'b0;
        end else if (pend && n_edge == n_acc + WIDTH) begin
            m_res  = ref_op(m_op, m_a, m_b);
            m_zero = (m_res == '0);
        end else if ((!pend || n_edge >= n_acc + WIDTH + 2) && bus.start) begin
            pend  = 1'b1;
            n_acc = n_edge;
            m_op  = bus.op;
            m_a   = bus.a;
            m_b   = bus.b;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",   32'(bus.busy),   32'(pend && (n_edge - n_acc) < WIDTH));
            chk("done",   32'(bus.done),   32'(pend && (n_edge - n_acc) == WIDTH));
            chk("result", 32'(bus.result), 32'(m_res));
            chk("zero",   32'(bus.zero),   32'(m_zero));
        end
    end

    task automatic wait_done(input string nm, output int busy_n);
        bit seen;
        seen   = 1'b0;
        busy_n = 0;
        for (int i = 0; i < 4 * WIDTH && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
            else if (bus.busy) busy_n++;
        end
        chk({nm, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic run_op(input string nm, input logic [1:0] o,
                          input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic [WIDTH-1:0] exp);
        int busy_n;
        @(posedge clk); #2;
        bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        @(posedge clk); #2;
        bus.start = 1'b0;
        bus.op = 2'($urandom); bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom);
        wait_done(nm, busy_n);
        chk({nm, "_busy_cycles"}, 32'(busy_n), 32'(WIDTH));
        chk({nm, "_result"}, 32'(bus.result), 32'(exp));
        chk({nm, "_zero"}, 32'(bus.zero), 32'(exp == '0));
        chk({nm, "_model"}, 32'(m_res), 32'(exp));
        @(negedge clk);
        chk({nm, "_done_1cyc"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int busy_n;
        int no_done;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy",   32'(bus.busy),   32'd0);
        chk("rst_done",   32'(bus.done),   32'd0);
        chk("rst_result", 32'(bus.result), 32'h0);
        chk("rst_zero",   32'(bus.zero),   32'd0);
        chk_en = 1'b1;

        run_op("xor",   2'b00, 16'hA5A5, 16'h0FF0, 16'hAA55);
        run_op("xnor",  2'b11, 16'h1234, 16'h1234, 16'hFFFF);
        run_op("xor0",  2'b00, 16'h1234, 16'h1234, 16'h0000);
        run_op("and",   2'b01, 16'hFFFF, 16'h8001, 16'h8001);
        run_op("or",    2'b10, 16'h0000, 16'h0000, 16'h0000);

        // start held high across an operation, operand changed mid-run
        @(posedge clk); #2;
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 16'h1111; bus.b = 16'h0F0F;
        @(posedge clk); #2;
        bus.a = 16'h2222;
        wait_done("hold1", busy_n);
        chk("hold1_result", 32'(bus.result), 32'h1E1E);
        @(negedge clk);
        chk("hold_idle_gap", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("hold_reaccept", 32'(bus.busy), 32'd1);
        @(posedge clk); #2;
        bus.start = 1'b0;
        wait_done("hold2", busy_n);
        chk("hold2_result", 32'(bus.result), 32'h2D2D);

        // reset on the 8th RUN cycle aborts the operation
        @(posedge clk); #2;
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 16'h1234; bus.b = 16'h00FF;
        @(posedge clk); #2;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy",   32'(bus.busy),   32'd0);
        chk("abort_result", 32'(bus.result), 32'h0);
        no_done = 0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            @(negedge clk);
            if (bus.done) no_done++;
        end
        chk("abort_no_done", 32'(no_done), 32'd0);
        run_op("post_rst", 2'b00, 16'h00FF, 16'hFFFF, 16'hFF00);

        // randomized traffic: start, operands and occasional reset every cycle
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            bus.start = ($urandom_range(0, 3) == 0);
            bus.op    = 2'($urandom);
            bus.a     = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
            bus.b     = ($urandom_range(0, 7) == 0) ? bus.a : WIDTH'($urandom);
            rst       = ($urandom_range(0, 199) == 0);
        end
        @(posedge clk); #2;
        rst = 1'b0; bus.start = 1'b0;
        repeat (WIDTH + 4) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
